alu64_share_arbiter: RTL and testbench
======================================

Name: alu64_share_arbiter

Overview:
- Time-shares one ALU_64b instance between two requesters: requester 0 is the main datapath issue stage, requester 1 is the branch/compare unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block registers operands and the ALU control code, drives the external ALU, then captures Result/Overflow/Zero and returns them to the granted requester.
- Undefined ALU control codes are rejected with an error response and never reach the ALU.

Parameters:
- WIDTH, 64, operand/result width; must match the ALU.
- RR_EN, 1, 1 = round-robin priority; 0 = fixed priority with requester 0 winning.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  bit k: requester k presents a request
- req_ready  out  2  bit k: request k accepted this cycle
- req_a0, req_b0  in  WIDTH each  operands, requester 0
- req_a1, req_b1  in  WIDTH each  operands, requester 1
- req_op0, req_op1  in  4 each  ALU control {Ainvert, Binvert, Operation[1:0]}
- resp_valid  out  2  bit k: response pending for requester k
- resp_ready  in  2  bit k: requester k consumes response
- resp_result  out  WIDTH  captured result
- resp_ovf  out  1  captured Overflow
- resp_zero  out  1  captured Zero
- resp_err  out  1  illegal op code
- alu_a, alu_b  out  WIDTH each  to ALU a, b
- alu_op  out  4  to ALU ALUOperatn
- alu_result  in  WIDTH  from ALU Result
- alu_ovf  in  1  from ALU Overflow
- alu_zero  in  1  from ALU Zero

Behaviour:
- Reset values: all outputs 0, state IDLE, priority pointer = 0. A reset in any state aborts the operation in flight; no response is issued for it.
- Legal op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. All other codes are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with req_valid set; if both are set, the pointer's requester wins (RR_EN=1), else requester 0 wins (RR_EN=0).
  - req_ready[grant] = 1, combinational, only in IDLE; req_ready is 0 in all other states.
  - On handshake: latch a, b, op and grant id.
  - Legal op: load alu_a/alu_b/alu_op, go to EXEC.
  - Illegal op: load resp_result=0, resp_ovf=0, resp_zero=0, resp_err=1; alu_* unchanged; go to RESP.
- EXEC: one cycle. ALU is combinational, so at the clock edge capture alu_result, alu_ovf, alu_zero into resp_*, set resp_err=0, go to RESP.
- RESP:
  - resp_valid[id] = 1; the other bit stays 0.
  - resp_* hold stable until resp_ready[id]=1; resp_ready of the non-granted requester is ignored.
  - On consume: resp_valid cleared next cycle, go to IDLE; with RR_EN=1 the pointer moves to ~id.
- Latency (legal op): request accepted edge N → resp_valid high cycle N+2. Illegal op: N+1.
- Throughput: at most one request per 3 cycles (2 for illegal ops). Back-to-back requests start the cycle after the IDLE return.
- Requests are never lost: an ungranted req_valid stays pending. Requesters must hold req_valid and operands stable until req_ready.
- alu_a/alu_b/alu_op hold their last value between operations; the ALU is never re-driven while in RESP.
- Overflow is passed through unmodified for all ops; it is meaningful only for ADD/SUB.

Test Plan:
- Reset then req0 ADD a=5, b=7 → resp_valid=01 two cycles after acceptance; result=12, ovf=0, zero=0, err=0.
- req1 SUB a=0x7FFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF → result=0x8000000000000000, ovf=1; then SUB 9−9 → result=0, zero=1.
- Both req_valid=11 held, RR_EN=1, four ops → grants alternate 0,1,0,1. RR_EN=0 → all four go to requester 0 while its valid stays high.
- req0 op=0011 (illegal) → resp_valid=01 one cycle after acceptance; err=1, result=0; alu_op unchanged.
- resp_ready held 0 for 5 cycles in RESP → resp_* stable, req_ready=00; new req1 pending is granted the cycle after the IDLE return.
- rst asserted during EXEC → next cycle all outputs 0, state IDLE, no resp_valid; a fresh SLT a=−1, b=1 → result=1.

Source files
------------

// File: rtl/alu64_share_arbiter.sv
// Time-shares one external combinational 64-bit ALU between two valid/ready requesters.
// Latency: legal op responds 2 edges after acceptance, illegal op 1 edge; backpressure holds RESP until the owner consumes.
// Requests are accepted only in IDLE; an ungranted requester simply stays pending.
module alu64_share_arbiter #(
    parameter int WIDTH = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_ovf,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state;
    logic             ptr;
    logic             id;
    logic             gnt;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [3:0]       sel_op;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        if (req_valid == 2'b11)
            gnt = RR_EN ? ptr : 1'b0;
        else
            gnt = req_valid[1];
        sel_a  = gnt ? req_a1  : req_a0;
        sel_b  = gnt ? req_b1  : req_b0;
        sel_op = gnt ? req_op1 : req_op0;
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00)
            req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            id          <= 1'b0;
            resp_valid  <= 2'b00;
            resp_result <= '0;
            resp_ovf    <= 1'b0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        id <= gnt;
                        if (op_legal(sel_op)) begin
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                            state  <= EXEC;
                        end else begin
                            // Illegal codes bypass the ALU entirely; its inputs keep the last legal op.
                            resp_result <= '0;
                            resp_ovf    <= 1'b0;
                            resp_zero   <= 1'b0;
                            resp_err    <= 1'b1;
                            resp_valid  <= 2'b01 << gnt;
                            state       <= RESP;
                        end
                    end
                end
                EXEC: begin
                    resp_result <= alu_result;
                    resp_ovf    <= alu_ovf;
                    resp_zero   <= alu_zero;
                    resp_err    <= 1'b0;
                    resp_valid  <= 2'b01 << id;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready[id]) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                        if (RR_EN)
                            ptr <= ~id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu64_share_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share stimulus, each with its own ALU model.
module tb_alu64_share_arbiter;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  resp_ready = 2'b00;
    logic [63:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]  req_op0 = '0, req_op1 = '0;

    logic [1:0]  req_ready, resp_valid;
    logic [63:0] resp_result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        resp_ovf, resp_zero, resp_err, alu_ovf, alu_zero;

    logic [1:0]  req_ready_f, resp_valid_f;
    logic [63:0] resp_result_f, alu_a_f, alu_b_f, alu_result_f;
    logic [3:0]  alu_op_f;
    logic        resp_ovf_f, resp_zero_f, resp_err_f, alu_ovf_f, alu_zero_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [65:0] alu_model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        logic [63:0] aa, bb, sum, r;
        logic ovf;
        aa  = op[3] ? ~a : a;
        bb  = op[2] ? ~b : b;
        sum = aa + bb + {63'd0, op[2]};
        ovf = (aa[63] == bb[63]) && (sum[63] != aa[63]);
        case (op[1:0])
            2'b00:   r = aa & bb;
            2'b01:   r = aa | bb;
            2'b10:   r = sum;
            default: r = {63'd0, sum[63] ^ ovf};
        endcase
        return {ovf, (r == 64'd0), r};
    endfunction

    assign {alu_ovf, alu_zero, alu_result}       = alu_model(alu_a, alu_b, alu_op);
    assign {alu_ovf_f, alu_zero_f, alu_result_f} = alu_model(alu_a_f, alu_b_f, alu_op_f);

    alu64_share_arbiter #(.WIDTH(64), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_ovf(resp_ovf), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_zero(alu_zero)
    );

    alu64_share_arbiter #(.WIDTH(64), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_f),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .resp_valid(resp_valid_f), .resp_ready(resp_ready),
        .resp_result(resp_result_f), .resp_ovf(resp_ovf_f), .resp_zero(resp_zero_f), .resp_err(resp_err_f),
        .alu_a(alu_a_f), .alu_b(alu_b_f), .alu_op(alu_op_f),
        .alu_result(alu_result_f), .alu_ovf(alu_ovf_f), .alu_zero(alu_zero_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int k, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        if (k == 0) begin
            req_a0 = a; req_b0 = b; req_op0 = op; req_valid[0] = 1'b1;
        end else begin
            req_a1 = a; req_b1 = b; req_op1 = op; req_valid[1] = 1'b1;
        end
        #1;
    endtask

    task automatic consume(input logic [1:0] k);
        resp_ready = k;
        tick();
        resp_ready = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b00;
        do_reset();
        tick();
        checks++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_valid: resp_valid=%b req_ready=%b, want 00 00", resp_valid, req_ready);
        end
        checks++;
        if (resp_result !== 64'd0 || resp_err !== 1'b0 || resp_ovf !== 1'b0 || resp_zero !== 1'b0) begin
            errors++; $display("FAIL reset_resp: result=%h err=%b ovf=%b zero=%b, want zeros", resp_result, resp_err, resp_ovf, resp_zero);
        end
        checks++;
        if (alu_a !== 64'd0 || alu_b !== 64'd0 || alu_op !== 4'd0 || alu_op_f !== 4'd0) begin
            errors++; $display("FAIL reset_alu: a=%h b=%h op=%b, want zeros", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_add();
        present(0, 64'd5, 64'd7, OP_ADD);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL add_ready: req_ready=%b, want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL add_exec: resp_valid=%b req_ready=%b, want 00 00", resp_valid, req_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 2'b01 || resp_result !== 64'd12 || resp_ovf !== 1'b0 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL add_resp: valid=%b result=%0d ovf=%b zero=%b err=%b, want 01 12 0 0 0",
                               resp_valid, resp_result, resp_ovf, resp_zero, resp_err);
        end
        consume(2'b01);
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++; $display("FAIL add_consume: resp_valid=%b, want 00", resp_valid);
        end
    endtask

    task automatic test_sub();
        present(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, OP_SUB);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL sub_ready: req_ready=%b, want 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b10 || resp_result !== 64'h8000_0000_0000_0000 || resp_ovf !== 1'b1 || resp_err !== 1'b0) begin
            errors++; $display("FAIL sub_ovf: valid=%b result=%h ovf=%b err=%b, want 10 8000000000000000 1 0",
                               resp_valid, resp_result, resp_ovf, resp_err);
        end
        consume(2'b10);
        present(1, 64'd9, 64'd9, OP_SUB);
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b10 || resp_result !== 64'd0 || resp_zero !== 1'b1 || resp_ovf !== 1'b0) begin
            errors++; $display("FAIL sub_zero: valid=%b result=%h zero=%b ovf=%b, want 10 0 1 0",
                               resp_valid, resp_result, resp_zero, resp_ovf);
        end
        consume(2'b10);
    endtask

    task automatic test_illegal();
        present(0, 64'd3, 64'd4, 4'b0011);
        tick();
        req_valid = 2'b00;
        checks++;
        if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_result !== 64'd0 || resp_zero !== 1'b0 || resp_ovf !== 1'b0) begin
            errors++; $display("FAIL illegal_resp: valid=%b err=%b result=%h zero=%b ovf=%b, want 01 1 0 0 0",
                               resp_valid, resp_err, resp_result, resp_zero, resp_ovf);
        end
        checks++;
        if (alu_op !== OP_SUB || alu_a !== 64'd9 || alu_b !== 64'd9) begin
            errors++; $display("FAIL illegal_alu: op=%b a=%0d b=%0d, want 0110 9 9", alu_op, alu_a, alu_b);
        end
        consume(2'b01);
    endtask

    task automatic test_hold();
        present(0, 64'hF0F0, 64'h0F0F, OP_OR);
        tick();
        req_valid = 2'b00;
        tick();
        present(1, 64'hF0F0, 64'h0FF0, OP_AND);
        resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 2'b01 || req_ready !== 2'b00 || resp_result !== 64'hFFFF) begin
                errors++; $display("FAIL hold_%0d: valid=%b req_ready=%b result=%h, want 01 00 ffff",
                                   i, resp_valid, req_ready, resp_result);
            end
            tick();
        end
        consume(2'b01);
        checks++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin
            errors++; $display("FAIL hold_return: valid=%b req_ready=%b, want 00 10", resp_valid, req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b10 || resp_result !== 64'h00F0) begin
            errors++; $display("FAIL hold_pending: valid=%b result=%h, want 10 00f0", resp_valid, resp_result);
        end
        consume(2'b10);
    endtask

    task automatic test_back_to_back();
        logic gr [4];
        logic gf [4];
        int nr = 0;
        int nf = 0;
        do_reset();
        req_a0 = 64'd1;  req_b0 = 64'd1; req_op0 = OP_ADD;
        req_a1 = 64'd10; req_b1 = 64'd1; req_op1 = OP_SUB;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        for (int i = 0; i < 40 && (nr < 4 || nf < 4); i++) begin
            if (resp_valid != 2'b00 && nr < 4) begin gr[nr] = resp_valid[1]; nr++; end
            if (resp_valid_f != 2'b00 && nf < 4) begin gf[nf] = resp_valid_f[1]; nf++; end
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 2'b00;
        checks++;
        if (nr != 4 || nf != 4) begin
            errors++; $display("FAIL b2b_timeout: rr=%0d fp=%0d responses, want 4 4", nr, nf);
        end
        for (int i = 0; i < nr; i++) begin
            checks++;
            if (gr[i] !== i[0]) begin
                errors++; $display("FAIL rr_grant_%0d: got requester %0d, want %0d", i, gr[i], i[0]);
            end
        end
        for (int i = 0; i < nf; i++) begin
            checks++;
            if (gf[i] !== 1'b0) begin
                errors++; $display("FAIL fp_grant_%0d: got requester %0d, want 0", i, gf[i]);
            end
        end
    endtask

    task automatic test_reset_exec();
        do_reset();
        present(0, 64'd3, 64'd4, OP_ADD);
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (resp_valid !== 2'b00 || resp_result !== 64'd0 || alu_a !== 64'd0 || alu_op !== 4'd0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL rst_exec: valid=%b result=%h alu_a=%h alu_op=%b req_ready=%b, want all 0",
                               resp_valid, resp_result, alu_a, alu_op, req_ready);
        end
        tick();
        checks++;
        if (resp_valid !== 2'b00) begin
            errors++; $display("FAIL rst_no_resp: valid=%b, want 00", resp_valid);
        end
        present(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_SLT);
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (resp_valid !== 2'b01 || resp_result !== 64'd1 || resp_err !== 1'b0) begin
            errors++; $display("FAIL slt: valid=%b result=%h err=%b, want 01 1 0", resp_valid, resp_result, resp_err);
        end
        consume(2'b01);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
